// File: rtl/fu_logical_rs.sv
// Reservation station for the logical functional unit.
// Holds up to DEPTH dispatched instructions, wakes their sources from the
// writeback broadcast and issues the oldest ready entry through a registered
// bundle. Relative age is tracked with an age matrix, so it never wraps.
module fu_logical_rs #(
  parameter int DEPTH = 4,
  parameter int PRN_W = 7,
  parameter int ID_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [31:0]      disp_inst,
  input  logic [ID_W-1:0]  disp_inst_id,
  input  logic [PRN_W-1:0] disp_out_prn,
  input  logic [PRN_W-1:0] disp_src_prn  [3],
  input  logic             disp_src_rdy  [3],
  input  logic [63:0]      disp_src_data [3],
  input  logic             wb_valid,
  input  logic [PRN_W-1:0] wb_prn,
  input  logic [63:0]      wb_data,
  input  logic             fu_ready,
  output logic             iss_valid,
  output logic [31:0]      iss_inst,
  output logic [ID_W-1:0]  iss_inst_id,
  output logic [PRN_W-1:0] iss_out_prn,
  output logic [63:0]      iss_op [3]
);

  logic [DEPTH-1:0] valid;
  logic [31:0]      inst_q     [DEPTH];
  logic [ID_W-1:0]  id_q       [DEPTH];
  logic [PRN_W-1:0] out_prn_q  [DEPTH];
  logic [PRN_W-1:0] src_prn_q  [DEPTH][3];
  logic             src_rdy_q  [DEPTH][3];
  logic [63:0]      src_data_q [DEPTH][3];
  // older[i][j] set means entry i was allocated before entry j
  logic [DEPTH-1:0] older [DEPTH];

  logic [DEPTH-1:0] alloc_oh;
  logic             alloc_found;
  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] sel;
  logic             do_disp;
  logic             do_iss;
  logic             in_rdy  [3];
  logic [63:0]      in_data [3];
  logic [31:0]      sel_inst;
  logic [ID_W-1:0]  sel_id;
  logic [PRN_W-1:0] sel_out_prn;
  logic [63:0]      sel_op [3];

  // Full means no dispatch this cycle, even if an issue frees a slot.
  assign disp_ready = ~&valid;
  assign do_disp    = disp_valid & disp_ready & ~flush;
  assign do_iss     = fu_ready & (|elig) & ~flush;

  // Lowest-index free entry as a one-hot allocation vector.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // An entry is eligible from registered state only.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      elig[i] = valid[i] & src_rdy_q[i][0] & src_rdy_q[i][1] & src_rdy_q[i][2];
  end

  // Oldest eligible entry: no other eligible entry is older than it.
  always_comb begin
    sel = elig;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (j != i && elig[j] && older[j][i]) sel[i] = 1'b0;
  end

  // Same-cycle wakeup of a source that arrives not ready at dispatch.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      in_rdy[s]  = disp_src_rdy[s];
      in_data[s] = disp_src_data[s];
      if (!disp_src_rdy[s] && wb_valid && wb_prn == disp_src_prn[s]) begin
        in_rdy[s]  = 1'b1;
        in_data[s] = wb_data;
      end
    end
  end

  // Issue bundle mux over the one-hot selection.
  always_comb begin
    sel_inst    = '0;
    sel_id      = '0;
    sel_out_prn = '0;
    for (int s = 0; s < 3; s++) sel_op[s] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        sel_inst    = inst_q[i];
        sel_id      = id_q[i];
        sel_out_prn = out_prn_q[i];
        for (int s = 0; s < 3; s++) sel_op[s] = src_data_q[i][s];
      end
    end
  end

  // Entry storage: allocation, writeback capture and release on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++)
        for (int s = 0; s < 3; s++) src_rdy_q[i][s] <= 1'b0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_disp && alloc_oh[i]) begin
          valid[i]     <= 1'b1;
          inst_q[i]    <= disp_inst;
          id_q[i]      <= disp_inst_id;
          out_prn_q[i] <= disp_out_prn;
          for (int s = 0; s < 3; s++) begin
            src_prn_q[i][s]  <= disp_src_prn[s];
            src_rdy_q[i][s]  <= in_rdy[s];
            src_data_q[i][s] <= in_data[s];
          end
        end else begin
          if (do_iss && sel[i]) valid[i] <= 1'b0;
          for (int s = 0; s < 3; s++) begin
            if (valid[i] && !src_rdy_q[i][s] && wb_valid && wb_prn == src_prn_q[i][s]) begin
              src_rdy_q[i][s]  <= 1'b1;
              src_data_q[i][s] <= wb_data;
            end
          end
        end
      end
    end
  end

  // Age matrix: a new entry is younger than every other entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (do_disp) begin
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          if (alloc_oh[i]) older[i][j] <= 1'b0;
          else if (alloc_oh[j]) older[i][j] <= 1'b1;
    end
  end

  // Registered issue bundle; data holds when nothing issues.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      iss_valid <= 1'b0;
    end else if (do_iss) begin
      iss_valid   <= 1'b1;
      iss_inst    <= sel_inst;
      iss_inst_id <= sel_id;
      iss_out_prn <= sel_out_prn;
      for (int s = 0; s < 3; s++) iss_op[s] <= sel_op[s];
    end else begin
      iss_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fu_logical_rs.sv
// Directed testbench for fu_logical_rs: dispatch, wakeup, bypass, age
// ordering, stall, flush and reset behaviour.
module tb_fu_logical_rs;
  localparam int DEPTH = 4;
  localparam int PRN_W = 7;
  localparam int ID_W  = 6;

  logic             clk, rst, flush, disp_valid, disp_ready;
  logic [31:0]      disp_inst;
  logic [ID_W-1:0]  disp_inst_id;
  logic [PRN_W-1:0] disp_out_prn;
  logic [PRN_W-1:0] disp_src_prn  [3];
  logic             disp_src_rdy  [3];
  logic [63:0]      disp_src_data [3];
  logic             wb_valid;
  logic [PRN_W-1:0] wb_prn;
  logic [63:0]      wb_data;
  logic             fu_ready, iss_valid;
  logic [31:0]      iss_inst;
  logic [ID_W-1:0]  iss_inst_id;
  logic [PRN_W-1:0] iss_out_prn;
  logic [63:0]      iss_op [3];

  int total = 0;
  int bad   = 0;

  fu_logical_rs #(.DEPTH(DEPTH), .PRN_W(PRN_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_inst(disp_inst), .disp_inst_id(disp_inst_id), .disp_out_prn(disp_out_prn),
    .disp_src_prn(disp_src_prn), .disp_src_rdy(disp_src_rdy), .disp_src_data(disp_src_data),
    .wb_valid(wb_valid), .wb_prn(wb_prn), .wb_data(wb_data),
    .fu_ready(fu_ready), .iss_valid(iss_valid), .iss_inst(iss_inst),
    .iss_inst_id(iss_inst_id), .iss_out_prn(iss_out_prn), .iss_op(iss_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand value s of instruction id: top byte s+1, low bits the id.
  function automatic logic [63:0] opval(input logic [ID_W-1:0] id, input int s);
    logic [7:0] tag;
    tag = 8'(s + 1);
    return {tag, 50'd0, id};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb_valid   = 1'b0;
    flush      = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic set_disp(input logic [ID_W-1:0] id,
                          input logic [PRN_W-1:0] p0, input logic r0,
                          input logic [PRN_W-1:0] p1, input logic r1,
                          input logic [PRN_W-1:0] p2, input logic r2);
    disp_valid       = 1'b1;
    disp_inst        = 32'h9A80_0000 | 32'(id);
    disp_inst_id     = id;
    disp_out_prn     = {1'b0, id};
    disp_src_prn[0]  = p0; disp_src_rdy[0] = r0;
    disp_src_prn[1]  = p1; disp_src_rdy[1] = r1;
    disp_src_prn[2]  = p2; disp_src_rdy[2] = r2;
    for (int s = 0; s < 3; s++) disp_src_data[s] = opval(id, s);
  endtask

  task automatic set_wb(input logic [PRN_W-1:0] prn, input logic [63:0] data);
    wb_valid = 1'b1;
    wb_prn   = prn;
    wb_data  = data;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (iss_valid !== 1'b0) begin $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); bad++; end
    total++; if (disp_ready !== 1'b1) begin $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); bad++; end
  endtask

  task automatic test_csel();
    fu_ready = 1'b1;
    set_disp(6'd17, 7'd1, 1'b1, 7'd2, 1'b1, 7'd3, 1'b1);
    step();
    idle();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL csel_not_yet got=%b exp=0", iss_valid); bad++; end
    step();
    total++; if (iss_valid !== 1'b1) begin $display("FAIL csel_iss_valid got=%b exp=1", iss_valid); bad++; end
    total++; if (iss_inst !== 32'h9A80_0011) begin $display("FAIL csel_inst got=%h exp=9a800011", iss_inst); bad++; end
    total++; if (iss_inst_id !== 6'd17) begin $display("FAIL csel_id got=%0d exp=17", iss_inst_id); bad++; end
    total++; if (iss_out_prn !== 7'h11) begin $display("FAIL csel_out_prn got=%h exp=11", iss_out_prn); bad++; end
    total++; if (iss_op[0] !== 64'h0100_0000_0000_0011) begin $display("FAIL csel_op0 got=%h exp=0100000000000011", iss_op[0]); bad++; end
    total++; if (iss_op[1] !== 64'h0200_0000_0000_0011) begin $display("FAIL csel_op1 got=%h exp=0200000000000011", iss_op[1]); bad++; end
    total++; if (iss_op[2] !== 64'h0300_0000_0000_0011) begin $display("FAIL csel_op2 got=%h exp=0300000000000011", iss_op[2]); bad++; end
    step();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL csel_single_issue got=%b exp=0", iss_valid); bad++; end
  endtask

  task automatic test_wakeup();
    fu_ready = 1'b1;
    set_disp(6'd20, 7'd4, 1'b1, 7'd5, 1'b0, 7'd6, 1'b1);
    step();
    idle();
    step();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL wake_waiting got=%b exp=0", iss_valid); bad++; end
    set_wb(7'd5, 64'hDEAD);
    step();
    idle();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL wake_same_edge got=%b exp=0", iss_valid); bad++; end
    step();
    total++; if (iss_valid !== 1'b1) begin $display("FAIL wake_issue got=%b exp=1", iss_valid); bad++; end
    total++; if (iss_op[1] !== 64'hDEAD) begin $display("FAIL wake_op1 got=%h exp=dead", iss_op[1]); bad++; end
    total++; if (iss_op[0] !== 64'h0100_0000_0000_0014) begin $display("FAIL wake_op0 got=%h exp=0100000000000014", iss_op[0]); bad++; end
    step();
  endtask

  task automatic test_bypass();
    fu_ready = 1'b1;
    set_disp(6'd9, 7'd9, 1'b0, 7'd7, 1'b1, 7'd8, 1'b1);
    set_wb(7'd9, 64'h1234);
    step();
    idle();
    step();
    total++; if (iss_valid !== 1'b1) begin $display("FAIL bypass_issue got=%b exp=1", iss_valid); bad++; end
    total++; if (iss_op[0] !== 64'h1234) begin $display("FAIL bypass_op0 got=%h exp=1234", iss_op[0]); bad++; end
    total++; if (iss_inst_id !== 6'd9) begin $display("FAIL bypass_id got=%0d exp=9", iss_inst_id); bad++; end
    step();
  endtask

  task automatic test_age_full();
    fu_ready = 1'b1;
    set_disp(6'd50, 7'd20, 1'b0, 7'd1, 1'b1, 7'd1, 1'b1); step();
    set_disp(6'd51, 7'd10, 1'b0, 7'd1, 1'b1, 7'd1, 1'b1); step();
    set_disp(6'd52, 7'd21, 1'b0, 7'd1, 1'b1, 7'd1, 1'b1); step();
    set_disp(6'd53, 7'd1, 1'b1, 7'd10, 1'b0, 7'd1, 1'b1); step();
    set_disp(6'd54, 7'd1, 1'b1, 7'd1, 1'b1, 7'd1, 1'b1);
    total++; if (disp_ready !== 1'b0) begin $display("FAIL full_disp_ready got=%b exp=0", disp_ready); bad++; end
    disp_valid = 1'b0;
    set_wb(7'd99, 64'hBEEF);
    step();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL unmatched_wb got=%b exp=0", iss_valid); bad++; end
    set_wb(7'd10, 64'hCAFE);
    step();
    idle();
    total++; if (disp_ready !== 1'b0) begin $display("FAIL full_while_issue got=%b exp=0", disp_ready); bad++; end
    step();
    total++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd51) begin $display("FAIL age_first got=%b/%0d exp=1/51", iss_valid, iss_inst_id); bad++; end
    total++; if (iss_op[0] !== 64'hCAFE) begin $display("FAIL age_first_op0 got=%h exp=cafe", iss_op[0]); bad++; end
    step();
    total++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd53) begin $display("FAIL age_second got=%b/%0d exp=1/53", iss_valid, iss_inst_id); bad++; end
    total++; if (iss_op[1] !== 64'hCAFE) begin $display("FAIL age_second_op1 got=%h exp=cafe", iss_op[1]); bad++; end
    step();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL age_drained got=%b exp=0", iss_valid); bad++; end
    total++; if (disp_ready !== 1'b1) begin $display("FAIL age_freed got=%b exp=1", disp_ready); bad++; end
    do_flush();
  endtask

  // A reallocated low-index entry must stay younger than a higher-index one.
  task automatic test_back_to_back();
    fu_ready = 1'b1;
    set_disp(6'd41, 7'd1, 1'b1, 7'd1, 1'b1, 7'd1, 1'b1); step();
    set_disp(6'd40, 7'd30, 1'b0, 7'd1, 1'b1, 7'd1, 1'b1); step();
    total++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd41) begin $display("FAIL b2b_first got=%b/%0d exp=1/41", iss_valid, iss_inst_id); bad++; end
    set_disp(6'd42, 7'd1, 1'b1, 7'd30, 1'b0, 7'd1, 1'b1); step();
    idle();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL b2b_waiting got=%b exp=0", iss_valid); bad++; end
    set_wb(7'd30, 64'h77);
    step();
    idle();
    step();
    total++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd40) begin $display("FAIL b2b_oldest got=%b/%0d exp=1/40", iss_valid, iss_inst_id); bad++; end
    step();
    total++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd42) begin $display("FAIL b2b_younger got=%b/%0d exp=1/42", iss_valid, iss_inst_id); bad++; end
    step();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL b2b_drained got=%b exp=0", iss_valid); bad++; end
  endtask

  task automatic test_stall();
    fu_ready = 1'b0;
    set_disp(6'd60, 7'd1, 1'b1, 7'd1, 1'b1, 7'd1, 1'b1); step();
    set_disp(6'd61, 7'd1, 1'b1, 7'd1, 1'b1, 7'd1, 1'b1); step();
    idle();
    step();
    step();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL stall_hold got=%b exp=0", iss_valid); bad++; end
    total++; if (disp_ready !== 1'b1) begin $display("FAIL stall_disp_ready got=%b exp=1", disp_ready); bad++; end
    fu_ready = 1'b1;
    step();
    total++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd60) begin $display("FAIL stall_first got=%b/%0d exp=1/60", iss_valid, iss_inst_id); bad++; end
    step();
    total++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd61) begin $display("FAIL stall_second got=%b/%0d exp=1/61", iss_valid, iss_inst_id); bad++; end
    step();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL stall_drained got=%b exp=0", iss_valid); bad++; end
  endtask

  task automatic test_discard(input logic use_rst);
    fu_ready = 1'b0;
    set_disp(6'd1, 7'd1, 1'b1, 7'd1, 1'b1, 7'd1, 1'b1); step();
    set_disp(6'd2, 7'd1, 1'b1, 7'd1, 1'b1, 7'd1, 1'b1); step();
    set_disp(6'd3, 7'd1, 1'b1, 7'd1, 1'b1, 7'd1, 1'b1); step();
    set_disp(6'd7, 7'd1, 1'b1, 7'd1, 1'b1, 7'd1, 1'b1);
    fu_ready = 1'b1;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    step();
    idle();
    total++; if (iss_valid !== 1'b0) begin $display("FAIL discard%0d_iss_valid got=%b exp=0", use_rst, iss_valid); bad++; end
    total++; if (disp_ready !== 1'b1) begin $display("FAIL discard%0d_disp_ready got=%b exp=1", use_rst, disp_ready); bad++; end
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (iss_valid !== 1'b0) begin $display("FAIL discard%0d_late_issue got=%b exp=0 cycle=%0d", use_rst, iss_valid, k); bad++; end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; wb_valid = 1'b0; fu_ready = 1'b0;
    disp_inst = '0; disp_inst_id = '0; disp_out_prn = '0; wb_prn = '0; wb_data = '0;
    for (int s = 0; s < 3; s++) begin
      disp_src_prn[s] = '0; disp_src_rdy[s] = 1'b0; disp_src_data[s] = '0;
    end
    test_reset();
    test_csel();
    test_wakeup();
    test_bypass();
    test_age_full();
    test_back_to_back();
    test_stall();
    test_discard(1'b0);
    test_discard(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fu_logical_rs.md
FU_LOGICAL_RS -- requirements
Module: fu_logical_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of reservation-station entries (power of two, 2..8).
REQ-002 SHALL have parameter PRN_W, default 7, meaning physical register number width.
REQ-003 SHALL have parameter ID_W, default 6, meaning instruction id width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port flush  input  1  discard all held entries.
REQ-007 SHALL have port disp_valid  input  1  dispatch request.
REQ-008 SHALL have port disp_ready  output  1  a free entry exists (combinational from registered valid bits).
REQ-009 SHALL have port disp_inst / disp_inst_id / disp_out_prn  input  32 / ID_W / PRN_W  instruction word, id, destination PRN.
REQ-010 SHALL have port disp_src_prn[3] / disp_src_rdy[3] / disp_src_data[3]  input  PRN_W / 1 / 64 each  source PRNs, ready flags, values (op0=Xn, op1=Xm, op2=flags/cond).
REQ-011 SHALL have port wb_valid / wb_prn / wb_data  input  1 / PRN_W / 64  writeback broadcast.
REQ-012 SHALL have port fu_ready  input  1  downstream logical FU accepts an instruction.
REQ-013 SHALL have port iss_valid / iss_inst / iss_inst_id / iss_out_prn / iss_op[3]  output  1 / 32 / ID_W / PRN_W / 64 each  registered issue bundle to FU.

Function
REQ-014 SHALL accept dispatch when disp_valid & disp_ready, writing the lowest-index free entry, marking it valid and youngest.
REQ-015 SHALL, per entry and source, capture wb_data and set ready when wb_valid & !ready & wb_prn == src_prn.
REQ-016 SHALL bypass a wakeup arriving in the dispatch cycle: a dispatched source with rdy=0 whose PRN equals a valid wb_prn is stored ready with wb_data.
REQ-017 SHALL treat an entry as eligible only when valid and all three sources ready in registered state (wakeups this cycle make it eligible next cycle).
REQ-018 SHALL, when fu_ready=1 and an eligible entry exists, select the oldest eligible entry (age matrix or equivalent), register its bundle onto iss_* and set iss_valid=1 next cycle; latency dispatch-with-ready-operands to iss_valid = 1 cycle.
REQ-019 SHALL free the issued entry in the same edge that loads iss_*; it is reallocatable the following cycle.
REQ-020 SHALL drive iss_valid=0 next cycle when fu_ready=0 or no entry is eligible; iss_* data then don't-care but held.
REQ-021 SHALL issue at most one entry and accept at most one dispatch per cycle; simultaneous issue and dispatch both occur.
REQ-022 SHALL deassert disp_ready when all DEPTH entries valid, even if an issue frees one that cycle.
REQ-023 SHALL preserve relative age of remaining entries across issue and allocation; no age-counter wrap hazards.
REQ-024 SHALL ignore wakeups for PRNs matching no waiting source; multiple entries waiting on one PRN all wake.
REQ-025 SHALL, on flush, clear all valid bits and iss_valid next cycle; flush dominates concurrent dispatch (dispatch dropped).

Reset
REQ-026 SHALL, while rst=1, clear all entry valid bits, ages and ready bits, and set iss_valid=0; disp_ready=1 in the cycle after rst.
REQ-027 SHALL discard in-flight dispatch, wakeup and issue in any cycle where rst=1, mid-operation included.

Verification
REQ-028 SHALL check: dispatch CSEL with all rdy=1, fu_ready=1 -> iss_valid=1 next cycle, iss_op/out_prn/inst_id equal dispatched values.
REQ-029 SHALL check: dispatch src1 PRN 5 rdy=0, then wb_valid prn=5 data=0xDEAD -> issue two cycles after wakeup edge... i.e. iss_valid rises the cycle after entry becomes eligible, iss_op[1]=0xDEAD.
REQ-030 SHALL check: fill 4 entries all waiting -> disp_ready=0; single wb wakes entries 3 and 1 -> oldest (entry dispatched first) issues first, other next cycle.
REQ-031 SHALL check: dispatch with rdy=0 PRN 9 same cycle as wb prn=9 -> entry stored ready, issues next cycle.
REQ-032 SHALL check: fu_ready=0 with 2 eligible entries -> iss_valid=0, entries retained; fu_ready=1 -> issued oldest-first on consecutive cycles.
REQ-033 SHALL check: flush or rst with 3 valid entries and concurrent dispatch -> next cycle iss_valid=0, disp_ready=1, no later issue of old entries.
